sti_load_arbiter: RTL and testbench
===================================

# sti_load_arbiter

Round-robin front-end controller for the STI serializer. It shares the one serializer between four requesting sources. It picks one request at a time, drives the serializer's parallel-load interface and holds that word stable for the whole shift. It tracks completion through `so_valid`, acknowledges the winner, and issues the final `pi_end` once the system requests end-of-stream.

## Interface
- `GAP`, default 1: idle cycles (≥1) between the end of one shift and the next arbitration.
- `TIMEOUT`, default 4: cycles allowed after `load` for `so_valid` to rise before an error is flagged.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  4  per-source request; held high until the matching `ack`.
- `req_data`  in  64  source i word at [16i+15:16i].
- `req_len`  in  8  source i `pi_length` code at [2i+1:2i].
- `req_fill`, `req_msb`, `req_low`  in  4 each  per-source format bits.
- `end_req`  in  1  request stream termination.
- `so_valid`  in  1  serializer output-valid.
- `load`  out  1  one-cycle load strobe to the serializer.
- `pi_data`  out  16  registered word to the serializer.
- `pi_length`  out  2  registered length code.
- `pi_fill`, `pi_msb`, `pi_low`  out  1 each  registered format bits.
- `pi_end`  out  1  one-cycle end strobe.
- `ack`  out  4  one-cycle completion pulse for the granted source.
- `err`  out  1  one-cycle error pulse (timeout or length mismatch).
- `grant_id`  out  2  index of the current or last granted source.
- `busy`  out  1  high in every state except IDLE and HALT.
- `done`  out  1  sticky high after `pi_end` is issued.

## Operation
- States: IDLE, LOAD, WAIT_START, SHIFT, GAP, END, HALT.
- **IDLE:**
  - If any `req` is set, the winner is the first set bit searching from `last_grant+1` upward, mod 4.
  - Latch the winner's fields into `pi_*`, set `grant_id`, and go to LOAD.
  - Otherwise, if `end_req` is set, go to END. A pending `req` always beats `end_req`.
- **LOAD:** `load=1` for exactly one cycle. Clear the cycle counter and go to WAIT_START.
- **WAIT_START:**
  - If `so_valid=1`, go to SHIFT with bit counter = 1.
  - Otherwise increment the counter. When it reaches TIMEOUT, pulse `err`, issue no `ack`, and go to GAP.
- **SHIFT:**
  - While `so_valid=1`, increment the bit counter (6 bits).
  - When `so_valid=0`, pulse `ack[grant_id]` and go to GAP.
  - If the bit count ≠ 8×(`pi_length`+1), also pulse `err` in the same cycle.
- **GAP:**
  - Count GAP cycles, then go to IDLE.
  - `last_grant` updates to `grant_id` on GAP entry, including after a timeout, so a dead source cannot starve the others.
- **END:** `pi_end=1` for one cycle, then go to HALT and set `done=1`.
- **HALT:** terminal state. `req` and `end_req` are ignored until reset.
- `pi_*` registers change only on an IDLE→LOAD transition. They stay constant from `load` through the end of GAP, because the serializer reads them combinationally during the shift.
- Fields are latched at grant, so a source may change its fields after grant. It must keep `req` high until `ack`, and must drop `req` in the cycle after `ack`, or it is re-arbitrated as a new request.
- After an `err` from a timeout, the source still sees no `ack`. It keeps requesting and is retried when round-robin reaches it again.

## Timing
- **Reset values:** all outputs 0, `last_grant`=3 (so source 0 wins first), state IDLE. Reset mid-shift aborts immediately; all outputs are 0 on the next cycle.
- **Grant latency:** `req` seen in IDLE at edge T → `load` high during cycle T+1 → WAIT_START at T+2.
- **Serializer response:** `so_valid` rises 1 cycle after the `load` cycle, and stays high 8/16/24/32 cycles for length codes 0/1/2/3.
- **Ack timing:** `ack` is asserted in the first cycle `so_valid` is observed low.
- **Back-to-back:** the next `load` comes no earlier than GAP+2 cycles after `ack`.
- **Simultaneous events:** simultaneous requests are resolved purely by round-robin order, with no fixed priority.
- **Outputs:** `ack`, `err`, `load` and `pi_end` are each exactly one cycle wide and never assert in HALT.

## Test plan
- **Single source:** `req`=0001, len=0, data=16'hA55A, msb=1, low=0. Expect `load` at T+1, 8 valid bits, `ack`=0001 once, `err`=0, and `pi_data` held at A55A through GAP.
- **Round-robin:** `req`=1111 held, with each source dropping its request after its `ack`. Expect grant order 0,1,2,3 and four `ack` pulses.
- **Rotation:** re-raise `req`=1001 while last_grant=0. Expect source 3 granted before source 0.
- **Timeout:** tie `so_valid`=0 with `req`=0010. Expect `err` pulse TIMEOUT cycles after the `load` cycle, no `ack`, then a retry of source 1 after GAP.
- **Length mismatch:** len=3 with `so_valid` high only 16 cycles. Expect `ack` and `err` in the same cycle.
- **End and reset:**
  - `end_req`=1 with `req`=0100 pending: source 2 is served first, then `pi_end` pulses one cycle, `done`=1, and later `req` is ignored.
  - Assert reset mid-SHIFT: all outputs return to 0 and arbitration restarts with source 0 first.

Source files
------------

// File: rtl/sti_load_arbiter.sv
// -----------------------------------------------------------------------------
// sti_load_arbiter
//
// Round-robin front end for the STI serializer. Four sources compete for the
// single serializer. One winner at a time has its word and format fields
// latched into the pi_* registers. Those registers stay frozen from the load
// strobe through the end of the inter-shift gap, because the serializer reads
// them combinationally while it shifts. Completion is tracked through
// so_valid. The winner gets a one-cycle ack, or an err pulse on a timeout or a
// length mismatch. When end_req is seen with no pending request, a final
// pi_end is issued and the block parks in HALT until reset.
//
// Parameters
//   GAP      idle cycles (>=1) between the end of a shift and the next arbitration
//   TIMEOUT  cycles allowed after load for so_valid to rise
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req[3:0]              per-source request, held until the matching ack
//   req_data[63:0]        source i word at [16i+15:16i]
//   req_len[7:0]          source i length code at [2i+1:2i]
//   req_fill/msb/low[3:0] per-source format bits
//   end_req               end-of-stream request
//   so_valid              serializer output-valid
//   load                  one-cycle load strobe
//   pi_data/length/fill/msb/low  registered parallel-load fields
//   pi_end                one-cycle end strobe
//   ack[3:0]              one-cycle completion pulse for the granted source
//   err                   one-cycle error pulse (timeout or length mismatch)
//   grant_id[1:0]         current or last granted source
//   busy                  high in every state except IDLE and HALT
//   done                  sticky, set once pi_end has been issued
// -----------------------------------------------------------------------------
module sti_load_arbiter #(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] req_data,
  input  logic [7:0]  req_len,
  input  logic [3:0]  req_fill,
  input  logic [3:0]  req_msb,
  input  logic [3:0]  req_low,
  input  logic        end_req,
  input  logic        so_valid,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic [3:0]  ack,
  output logic        err,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_SHIFT      = 3'd3,
    ST_GAP        = 3'd4,
    ST_END        = 3'd5,
    ST_HALT       = 3'd6
  } state_t;

  // Terminal counts for the shared cycle counter (timeout wait and gap wait).
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [5:0]  bit_reg, bit_next;
  logic [1:0]  last_grant_reg;
  logic [1:0]  grant_reg;
  logic [15:0] pi_data_reg;
  logic [1:0]  pi_length_reg;
  logic        pi_fill_reg, pi_msb_reg, pi_low_reg;
  logic        done_reg;

  logic        win_valid;
  logic [1:0]  win_id;
  logic        grant_take;
  logic        gap_enter;
  logic        ack_fire;
  logic [5:0]  exp_bits;

  // Per-source field views of the packed request buses.
  logic [15:0] src_data [4];
  logic [1:0]  src_len  [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      assign src_data[gi] = req_data[16*gi +: 16];
      assign src_len[gi]  = req_len[2*gi +: 2];
      // Only the granted source sees the completion pulse.
      assign ack[gi]      = ack_fire && (grant_reg == 2'(gi));
    end
  endgenerate

  // Round robin: scan upward starting one past the last grant, so the most
  // recently served source is considered last.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_valid && req[last_grant_reg + 2'(k)]) begin
        win_valid = 1'b1;
        win_id    = last_grant_reg + 2'(k);
      end
    end
  end

  // Expected shift length is 8 * (code + 1): 8, 16, 24 or 32 bits.
  assign exp_bits = {({1'b0, pi_length_reg} + 3'd1), 3'b000};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    grant_take = 1'b0;
    gap_enter  = 1'b0;
    ack_fire   = 1'b0;
    err        = 1'b0;
    load       = 1'b0;
    pi_end     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A pending request always beats end_req.
        if (win_valid) begin
          grant_take = 1'b1;
          state_next = ST_LOAD;
        end else if (end_req) begin
          state_next = ST_END;
        end
      end
      ST_LOAD: begin
        load       = 1'b1;
        cnt_next   = 8'd0;
        state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (so_valid) begin
          bit_next   = 6'd1;
          state_next = ST_SHIFT;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          // A timeout gets no ack. The source keeps requesting and is
          // retried when its round-robin turn comes back.
          err        = 1'b1;
          gap_enter  = 1'b1;
          cnt_next   = 8'd0;
          state_next = ST_GAP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (so_valid) begin
          bit_next = bit_reg + 6'd1;
        end else begin
          ack_fire   = 1'b1;
          err        = (bit_reg != exp_bits);
          gap_enter  = 1'b1;
          cnt_next   = 8'd0;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_END: begin
        pi_end     = 1'b1;
        state_next = ST_HALT;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 8'd0;
      bit_reg        <= 6'd0;
      last_grant_reg <= 2'd3;   // source 0 wins the first arbitration
      grant_reg      <= 2'd0;
      pi_data_reg    <= 16'd0;
      pi_length_reg  <= 2'd0;
      pi_fill_reg    <= 1'b0;
      pi_msb_reg     <= 1'b0;
      pi_low_reg     <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      // The pi_* fields change only at grant time and stay frozen until
      // the next grant.
      if (grant_take) begin
        grant_reg     <= win_id;
        pi_data_reg   <= src_data[win_id];
        pi_length_reg <= src_len[win_id];
        pi_fill_reg   <= req_fill[win_id];
        pi_msb_reg    <= req_msb[win_id];
        pi_low_reg    <= req_low[win_id];
      end
      // last_grant also advances after a timeout, so a dead source cannot
      // starve the others.
      if (gap_enter) begin
        last_grant_reg <= grant_reg;
      end
      if (state_reg == ST_END) begin
        done_reg <= 1'b1;
      end
    end
  end

  assign pi_data   = pi_data_reg;
  assign pi_length = pi_length_reg;
  assign pi_fill   = pi_fill_reg;
  assign pi_msb    = pi_msb_reg;
  assign pi_low    = pi_low_reg;
  assign grant_id  = grant_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_HALT);

endmodule

// File: tb/tb_sti_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sti_load_arbiter
//
// Directed testbench for sti_load_arbiter. A small serializer model raises
// so_valid one cycle after load and holds it for 8*(pi_length+1) cycles. The
// hold length can be overridden to model a dead or short shift. Expected
// grants and completion events are queued when the stimulus is set up. They
// are popped and compared when the DUT shows load, ack or err.
// -----------------------------------------------------------------------------
module tb_sti_load_arbiter;

  localparam int GAP     = 1;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [7:0]  req_len;
  logic [3:0]  req_fill, req_msb, req_low;
  logic        end_req;
  logic        so_valid;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end;
  logic [3:0]  ack;
  logic        err;
  logic [1:0]  grant_id;
  logic        busy, done;
  logic [31:0] all_outs;

  always #5 clk = ~clk;

  sti_load_arbiter #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_len(req_len),
    .req_fill(req_fill), .req_msb(req_msb), .req_low(req_low), .end_req(end_req),
    .so_valid(so_valid), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .ack(ack), .err(err), .grant_id(grant_id), .busy(busy), .done(done)
  );

  assign all_outs = {load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
                     ack, err, grant_id, busy, done};

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill, msb, low;
  } grant_t;

  typedef struct {
    logic [3:0] ack;
    logic       err;
  } done_t;

  grant_t grant_q[$];
  done_t  done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0, load_cnt = 0, evt_cnt = 0, pend_cnt = 0;
  int last_load_cyc = 0, last_evt_cyc = 0, pend_cyc = 0, gap_meas = 0;
  int ser_rem = 0;
  int ser_override = -1;
  logic [20:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: monitor and scoreboard at the falling edge, then drive
  // the serializer model and the request drops just after the rising edge.
  task automatic tick();
    logic [3:0] drop;
    grant_t g;
    done_t  d;
    @(negedge clk);
    cyc++;
    drop = ack;
    if (load) begin
      load_cnt++;
      gap_meas      = cyc - last_evt_cyc;
      last_load_cyc = cyc;
      if (grant_q.size() == 0) begin
        chk("load_unexpected", 32'(load), 32'd0);
      end else begin
        g = grant_q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(g.id));
        chk("pi_data", 32'(pi_data), 32'(g.data));
        chk("pi_fmt", 32'({pi_length, pi_fill, pi_msb, pi_low}),
            32'({g.len, g.fill, g.msb, g.low}));
      end
      held    = {pi_data, pi_length, pi_fill, pi_msb, pi_low};
      ser_rem = (ser_override >= 0) ? ser_override : 8 * (int'(pi_length) + 1);
    end else if (busy) begin
      chk("pi_hold", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'(held));
    end
    if ((ack != 4'd0) || err) begin
      evt_cnt++;
      last_evt_cyc = cyc;
      if (done_q.size() == 0) begin
        chk("event_unexpected", 32'({ack, err}), 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("ack", 32'(ack), 32'(d.ack));
        chk("err", 32'(err), 32'(d.err));
      end
    end
    if (pi_end) begin
      pend_cnt++;
      pend_cyc = cyc;
    end
    @(posedge clk);
    #1;
    req = req & ~drop;
    if (reset) ser_rem = 0;
    so_valid = (ser_rem > 0);
    if (ser_rem > 0) ser_rem--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_events(input int target, input int bound);
    int k = 0;
    while (evt_cnt < target && k < bound) begin
      tick();
      k++;
    end
    chk("event_count", 32'(evt_cnt), 32'(target));
  endtask

  task automatic set_src(input int i, input logic [15:0] d, input logic [1:0] l,
                         input logic f, input logic m, input logic lo);
    req_data[16*i +: 16] = d;
    req_len[2*i +: 2]    = l;
    req_fill[i]          = f;
    req_msb[i]           = m;
    req_low[i]           = lo;
  endtask

  task automatic exp_grant(input int id);
    grant_t g;
    g.id   = 2'(id);
    g.data = req_data[16*id +: 16];
    g.len  = req_len[2*id +: 2];
    g.fill = req_fill[id];
    g.msb  = req_msb[id];
    g.low  = req_low[id];
    grant_q.push_back(g);
  endtask

  // bits = number of so_valid cycles the model will produce (0 = dead).
  task automatic exp_done(input int id, input int bits);
    done_t d;
    int    want;
    want  = 8 * (int'(req_len[2*id +: 2]) + 1);
    d.ack = (bits == 0) ? 4'd0 : 4'(1 << id);
    d.err = (bits == 0) || (bits != want);
    done_q.push_back(d);
  endtask

  task automatic exp_txn(input int id, input int bits);
    exp_grant(id);
    exp_done(id, bits);
  endtask

  initial begin
    int base;
    int k;
    reset = 1'b1; req = 4'd0; req_data = 64'd0; req_len = 8'd0;
    req_fill = 4'd0; req_msb = 4'd0; req_low = 4'd0; end_req = 1'b0; so_valid = 1'b0;

    // Reset state.
    tick(); tick();
    chk("reset_outs", all_outs, 32'd0);
    reset = 1'b0;
    tick();

    // Round robin from reset: 0,1,2,3, each source dropping after its ack.
    set_src(0, 16'h1111, 2'd0, 1'b0, 1'b1, 1'b0);
    set_src(1, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0);
    set_src(2, 16'h3333, 2'd2, 1'b0, 1'b0, 1'b1);
    set_src(3, 16'h4444, 2'd3, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) exp_txn(i, 8 * (i + 1));
    req = 4'b1111;
    wait_events(evt_cnt + 4, 300);
    chk("rr_b2b_gap", 32'(gap_meas), 32'(GAP + 2));
    idle(GAP + 2);

    // Single source: load latency, 8-bit shift, ack timing, fields held.
    set_src(0, 16'hA55A, 2'd0, 1'b0, 1'b1, 1'b0);
    exp_txn(0, 8);
    req  = 4'b0001;
    base = load_cnt;
    tick();
    chk("lat_no_load", 32'(load_cnt), 32'(base));
    tick();
    chk("lat_load", 32'(load_cnt), 32'(base + 1));
    wait_events(evt_cnt + 1, 60);
    chk("ack_latency", 32'(last_evt_cyc - last_load_cyc), 32'd9);
    idle(GAP + 2);
    chk("pi_keep_idle", 32'(pi_data), 32'h0000A55A);

    // Rotation: last grant is 0, so 3 is served before 0.
    exp_txn(3, 32);
    exp_txn(0, 8);
    req = 4'b1001;
    wait_events(evt_cnt + 2, 150);
    idle(GAP + 2);

    // Timeout on a dead serializer, then a successful retry of source 1.
    set_src(1, 16'hBEEF, 2'd0, 1'b1, 1'b0, 1'b1);
    ser_override = 0;
    exp_txn(1, 0);
    exp_txn(1, 8);
    req = 4'b0010;
    wait_events(evt_cnt + 1, 40);
    chk("timeout_lat", 32'(last_evt_cyc - last_load_cyc), 32'(TIMEOUT));
    ser_override = -1;
    wait_events(evt_cnt + 1, 60);
    chk("retry_gap", 32'(gap_meas), 32'(GAP + 2));
    idle(GAP + 2);

    // Length mismatch: code 3 but only 16 valid cycles -> ack and err together.
    set_src(2, 16'h5A5A, 2'd3, 1'b0, 1'b1, 1'b1);
    ser_override = 16;
    exp_txn(2, 16);
    req = 4'b0100;
    wait_events(evt_cnt + 1, 80);
    ser_override = -1;
    idle(GAP + 2);

    // End of stream with a pending request: request first, then pi_end.
    set_src(2, 16'h0F0F, 2'd0, 1'b1, 1'b1, 1'b0);
    exp_txn(2, 8);
    req     = 4'b0100;
    end_req = 1'b1;
    wait_events(evt_cnt + 1, 60);
    k = 0;
    while (pend_cnt < 1 && k < 20) begin
      tick();
      k++;
    end
    chk("pend_seen", 32'(pend_cnt), 32'd1);
    chk("pend_lat", 32'(pend_cyc - last_evt_cyc), 32'(GAP + 2));
    idle(3);
    chk("pend_once", 32'(pend_cnt), 32'd1);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    base = load_cnt;
    req  = 4'b0001;
    idle(15);
    chk("halt_no_load", 32'(load_cnt), 32'(base));
    chk("halt_done_sticky", 32'(done), 32'd1);

    // Leave HALT through reset.
    req = 4'd0; end_req = 1'b0; reset = 1'b1;
    tick();
    chk("reset_done_clear", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a shift aborts at once.
    set_src(1, 16'hC3C3, 2'd3, 1'b0, 1'b0, 1'b0);
    exp_grant(1);
    req  = 4'b0010;
    base = load_cnt;
    k    = 0;
    while (load_cnt == base && k < 10) begin
      tick();
      k++;
    end
    chk("abort_load", 32'(load_cnt), 32'(base + 1));
    idle(10);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    req   = 4'd0;
    #1;
    chk("abort_outs", all_outs, 32'd0);
    tick();
    chk("abort_outs_held", all_outs, 32'd0);
    reset = 1'b0;
    tick();

    // Arbitration restarts with source 0 ahead of source 3.
    exp_txn(0, 8);
    exp_txn(3, 32);
    req = 4'b1001;
    wait_events(evt_cnt + 2, 150);
    idle(GAP + 2);
    chk("queues_empty", 32'(grant_q.size() + done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
